// File: rtl/pipes_pkg.sv
// Shared bus types and constants for the core-side memory arbiter.
package pipes;

  localparam int CBUS_ADDR_W = 64;
  localparam int CBUS_DATA_W = 64;

  // Size code used for every instruction fetch (4 bytes).
  localparam logic [2:0] MSIZE4 = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CBUS_ADDR_W-1:0]   addr;
    logic [2:0]               size;
    logic [CBUS_DATA_W/8-1:0] strobe;
    logic [CBUS_DATA_W-1:0]   data;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/core_bus_arbiter_arb_select.sv
// Combinational priority / starvation decision between fetch and data buses.
module arb_select #(
  parameter int MAX_CONSEC = 4
) (
  input  logic       ireq_valid,
  input  logic       dreq_valid,
  input  logic [3:0] consec,
  output logic       grant_valid,
  output logic       grant_owner,
  output logic [3:0] consec_nxt
);
  import pipes::*;

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  // Data bus wins unless it has already taken MAX_CONSEC grants over a waiting fetch.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = 1'b0;
    consec_nxt  = consec;
    case ({ireq_valid, dreq_valid})
      2'b10: begin
        grant_valid = 1'b1;
        grant_owner = 1'b0;
        consec_nxt  = 4'd0;
      end
      2'b01: begin
        grant_valid = 1'b1;
        grant_owner = 1'b1;
        consec_nxt  = consec;
      end
      2'b11: begin
        grant_valid = 1'b1;
        if (consec < MAX_C) begin
          grant_owner = 1'b1;
          consec_nxt  = consec + 4'd1;
        end else begin
          grant_owner = 1'b0;
          consec_nxt  = 4'd0;
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant_owner = 1'b0;
        consec_nxt  = consec;
      end
    endcase
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one memory port between instruction-fetch and data buses, one transaction at a time.
module core_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_data_ok,
  output logic [31:0]         iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic                creq_is_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_ready,
  input  logic                cresp_last,
  input  logic [DATA_W-1:0]   cresp_data
);
  import pipes::*;

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic                owner_r;
  logic [3:0]          consec_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          size_r;
  logic [DATA_W/8-1:0] strobe_r;
  logic [DATA_W-1:0]   data_r;

  logic                grant_valid_s;
  logic                grant_owner_s;
  logic [3:0]          consec_nxt_s;
  logic                done_s;
  logic                take_s;

  arb_select #(.MAX_CONSEC(MAX_CONSEC)) u_sel (
    .ireq_valid  (ireq_valid),
    .dreq_valid  (dreq_valid),
    .consec      (consec_r),
    .grant_valid (grant_valid_s),
    .grant_owner (grant_owner_s),
    .consec_nxt  (consec_nxt_s)
  );

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and response routing; data_ok is a same-cycle pass-through of the last beat.
  always_comb begin
    state_nxt_s   = state_r;
    done_s        = 1'b0;
    take_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          take_s      = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cresp_ready && cresp_last) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    creq_valid    = (state_r == BUSY);
    creq_is_write = |strobe_r;
    creq_addr     = addr_r;
    creq_size     = size_r;
    creq_strobe   = strobe_r;
    creq_data     = data_r;
    iresp_data_ok = done_s & ~owner_r;
    dresp_data_ok = done_s & owner_r;
    if (done_s && !owner_r) begin
      iresp_data = cresp_data[31:0];
    end else begin
      iresp_data = 32'd0;
    end
    if (done_s && owner_r) begin
      dresp_data = cresp_data;
    end else begin
      dresp_data = {DATA_W{1'b0}};
    end
  end

  // Latch the winning request, its owner and the starvation count on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r  <= 1'b0;
      consec_r <= 4'd0;
      addr_r   <= {ADDR_W{1'b0}};
      size_r   <= 3'd0;
      strobe_r <= {(DATA_W/8){1'b0}};
      data_r   <= {DATA_W{1'b0}};
    end else if (take_s) begin
      owner_r  <= grant_owner_s;
      consec_r <= consec_nxt_s;
      if (grant_owner_s) begin
        addr_r   <= dreq_addr;
        size_r   <= dreq_size;
        strobe_r <= dreq_strobe;
        data_r   <= dreq_data;
      end else begin
        addr_r   <= ireq_addr;
        size_r   <= MSIZE4;
        strobe_r <= {(DATA_W/8){1'b0}};
        data_r   <= {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed scoreboard bench for core_bus_arbiter (built with MAX_CONSEC = 2).
module tb_core_bus_arbiter;
  import pipes::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_data_ok;
  logic [31:0]   iresp_data;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [SW-1:0] dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_data_ok;
  logic [DW-1:0] dresp_data;
  logic          creq_valid;
  logic          creq_is_write;
  logic [AW-1:0] creq_addr;
  logic [2:0]    creq_size;
  logic [SW-1:0] creq_strobe;
  logic [DW-1:0] creq_data;
  logic          cresp_ready;
  logic          cresp_last;
  logic [DW-1:0] cresp_data;

  core_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CONSEC(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .creq_valid    (creq_valid),
    .creq_is_write (creq_is_write),
    .creq_addr     (creq_addr),
    .creq_size     (creq_size),
    .creq_strobe   (creq_strobe),
    .creq_data     (creq_data),
    .cresp_ready   (cresp_ready),
    .cresp_last    (cresp_last),
    .cresp_data    (cresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [SW-1:0] strobe;
    logic [DW-1:0] data;
  } req_t;

  req_t exp_i[$];
  req_t exp_d[$];
  bit   ord_q[$];   // expected grant order: 0 = ibus, 1 = dbus
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_i(input logic [AW-1:0] a);
    ireq_valid = 1'b1;
    ireq_addr  = a;
    exp_i.push_back('{a, 3'b010, 8'h00, 64'h0});
  endtask

  task automatic issue_d(input logic [AW-1:0] a, input logic [2:0] sz, input logic [SW-1:0] st, input logic [DW-1:0] wd);
    dreq_valid  = 1'b1;
    dreq_addr   = a;
    dreq_size   = sz;
    dreq_strobe = st;
    dreq_data   = wd;
    exp_d.push_back('{a, sz, st, wd});
  endtask

  // Waits for creq_valid, checks it against the scoreboard, answers after delay cycles
  // with nolast non-final beats, then a final beat. Returns at posedge+1 after completion.
  task automatic serve(input int delay, input int nolast, input logic [DW-1:0] rdata, output int waited);
    req_t e;
    bit   own;
    bit   seen;
    bit   last;
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      waited++;
      if (creq_valid === 1'b1) seen = 1'b1;
    end
    chk("creq_valid_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("sb_nonempty", 64'(ord_q.size() > 0), 64'd1);
    if (ord_q.size() == 0) return;
    own = ord_q.pop_front();
    if (own) e = exp_d.pop_front();
    else     e = exp_i.pop_front();
    for (int c = 0; c <= delay + nolast; c++) begin
      last        = (c == delay + nolast);
      cresp_ready = (c >= delay);
      cresp_last  = last;
      cresp_data  = rdata;
      #1;
      chk("creq_valid",    64'(creq_valid), 64'd1);
      chk("creq_addr",     creq_addr, e.addr);
      chk("creq_size",     64'(creq_size), 64'(e.size));
      chk("creq_strobe",   64'(creq_strobe), 64'(e.strobe));
      chk("creq_data",     creq_data, e.data);
      chk("creq_is_write", 64'(creq_is_write), 64'(e.strobe != 8'h00));
      chk("iresp_data_ok", 64'(iresp_data_ok), 64'(last && !own));
      chk("dresp_data_ok", 64'(dresp_data_ok), 64'(last && own));
      if (last) begin
        chk("iresp_data", 64'(iresp_data), own ? 64'd0 : 64'(rdata[31:0]));
        chk("dresp_data", dresp_data, own ? rdata : 64'd0);
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;
  endtask

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit seen;
    bit own_tab[6]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int consec_tab[6] = '{1, 2, 0, 1, 2, 0};

    reset       = 1'b1;
    ireq_valid  = 1'b0;
    ireq_addr   = 64'h0;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'h0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'h00;
    dreq_data   = 64'h0;
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;

    // Reset state.
    #3;
    chk("rst_creq_valid", 64'(creq_valid), 64'd0);
    chk("rst_iresp_ok",   64'(iresp_data_ok), 64'd0);
    chk("rst_dresp_ok",   64'(dresp_data_ok), 64'd0);
    chk("rst_creq_addr",  creq_addr, 64'd0);
    chk("rst_consec",     64'(dut.consec_r), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fetch read with a 3-cycle downstream delay.
    @(posedge clk);
    #1;
    issue_i(64'h0000_0000_8000_0000);
    ord_q.push_back(1'b0);
    serve(3, 0, 64'h0000_0000_0010_0093, w);
    chk("fetch_latency", 64'(w), 64'd2);
    ireq_valid = 1'b0;

    // Simultaneous requests: store first, fetch in the IDLE cycle afterwards.
    issue_i(64'h0000_0000_8000_0100);
    issue_d(64'h0000_0000_8000_1000, 3'b011, 8'hFF, 64'h0000_0000_DEAD_BEEF);
    ord_q.push_back(1'b1);
    ord_q.push_back(1'b0);
    serve(1, 0, 64'h0000_0000_0000_1234, w);
    chk("simul_d_latency", 64'(w), 64'd2);
    chk("simul_consec_d",  64'(dut.consec_r), 64'd1);
    dreq_valid = 1'b0;
    serve(0, 0, 64'h0000_0000_0000_0013, w);
    chk("simul_i_turnaround", 64'(w), 64'd2);
    chk("simul_consec_i",     64'(dut.consec_r), 64'd0);
    ireq_valid = 1'b0;

    // Starvation guard (MAX_CONSEC = 2): d,d,i,d,d,i with both buses reissuing.
    issue_i(64'h0000_0000_8000_0200);
    issue_d(64'h0000_0000_8000_2000, 3'b011, 8'h00, 64'h0);
    for (int g = 0; g < 6; g++) ord_q.push_back(own_tab[g]);
    for (int g = 0; g < 6; g++) begin
      serve(0, 0, 64'hA5A5_0000_0000_0000 | 64'(g), w);
      chk("starve_latency", 64'(w), 64'd2);
      chk("starve_consec",  64'(dut.consec_r), 64'(consec_tab[g]));
      if (own_tab[g]) begin
        issue_d(64'h0000_0000_8000_2000 + 64'(8 * (g + 1)), 3'b011, 8'h00, 64'h0);
      end else if (g < 5) begin
        issue_i(64'h0000_0000_8000_0200 + 64'(4 * (g + 1)));
      end else begin
        ireq_valid = 1'b0;
      end
    end
    dreq_valid = 1'b0;
    exp_d.delete();

    // Multi-beat response on a partial store: one data_ok, on the final beat.
    issue_d(64'h0000_0000_8000_3000, 3'b011, 8'h0F, 64'h0000_0000_CAFE_F00D);
    ord_q.push_back(1'b1);
    serve(1, 2, 64'h0000_0000_0000_0055, w);
    chk("mbeat_latency", 64'(w), 64'd2);
    dreq_valid = 1'b0;

    // Reset asserted between clock edges during a final beat.
    issue_i(64'h0000_0000_8000_4000);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (creq_valid === 1'b1) seen = 1'b1;
    end
    chk("rstmid_busy", 64'(seen), 64'd1);
    cresp_ready = 1'b1;
    cresp_last  = 1'b1;
    cresp_data  = 64'h0000_0000_0000_0077;
    #1;
    chk("rstmid_ok_before", 64'(iresp_data_ok), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_creq_valid", 64'(creq_valid), 64'd0);
    chk("rstmid_iresp_ok",   64'(iresp_data_ok), 64'd0);
    chk("rstmid_dresp_ok",   64'(dresp_data_ok), 64'd0);
    chk("rstmid_iresp_data", 64'(iresp_data), 64'd0);
    chk("rstmid_state",      64'(dut.state_r), 64'(IDLE));
    chk("rstmid_creq_addr",  creq_addr, 64'd0);
    ireq_valid  = 1'b0;
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;
    exp_i.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue_i(64'h0000_0000_8000_5000);
    ord_q.push_back(1'b0);
    serve(0, 0, 64'h0000_0000_0000_0213, w);
    chk("post_rst_latency", 64'(w), 64'd2);
    ireq_valid = 1'b0;

    // Idle hold: nothing requested for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_creq_valid", 64'(creq_valid), 64'd0);
    end
    chk("idle_consec", 64'(dut.consec_r), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
